// File: rtl/key_queue.sv
// key_queue: byte FIFO between the UART receiver and the ASCII-to-PS/2
// converter. Bytes are released one at a time as a single-cycle latch pulse,
// and only after the downstream PS/2 path has been idle for GAP_CYCLES
// consecutive cycles.
// Optional feature macro: KEY_QUEUE_DROP_STATS_EN enables the overflow flag
// and the saturating drop counter. Without it, both outputs are tied to 0.
// Bytes are still dropped when the queue is full.
module key_queue #(
    parameter int DEPTH      = 16,
    parameter int GAP_CYCLES = 50000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [7:0]               in_data,
    input  logic                     sink_idle,
    output logic                     out_latch,
    output logic [7:0]               out_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full,
    output logic                     overflow,
    output logic [7:0]               drop_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam logic [GW-1:0] GAP_MAX = GW'(GAP_CYCLES);
    localparam logic [AW:0]   CNT_MAX = (AW + 1)'(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          empty_q, empty_d, full_q, full_d;
    logic [GW-1:0] gap_q, gap_d;
    logic          latch_q, latch_d;
    logic [7:0]    data_q, data_d;
    logic          issue, push, drop;

    // Issue and push decisions from registered state. A full queue still
    // accepts a byte on an issue edge, because the issue frees the head slot.
    always_comb begin
        issue    = !empty_q && (gap_q == GAP_MAX);
        push     = in_valid && (!full_q || issue);
        drop     = in_valid && full_q && !issue;
        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(issue);
        count_d  = count_q;
        if (push && !issue)
            count_d = count_q + 1'b1;
        else if (issue && !push)
            count_d = count_q - 1'b1;
        empty_d  = (count_d == '0);
        full_d   = (count_d == CNT_MAX);
        latch_d  = issue;
        data_d   = issue ? mem_q[rd_ptr_q] : data_q;
    end

    // Settle counter. An issue restarts it, and so does any busy cycle.
    always_comb begin
        gap_d = gap_q;
        if (issue || !sink_idle)
            gap_d = '0;
        else if (gap_q != GAP_MAX)
            gap_d = gap_q + 1'b1;
    end

    // Queue storage. The contents need no reset because count gates all reads.
    always_ff @(posedge clk) begin
        if (push)
            mem_q[wr_ptr_q] <= in_data;
    end

    // Pointers, occupancy, gap counter and the issue output register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            gap_q    <= '0;
            latch_q  <= 1'b0;
            data_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
            gap_q    <= gap_d;
            latch_q  <= latch_d;
            data_q   <= data_d;
        end
    end

    assign out_latch = latch_q;
    assign out_data  = data_q;
    assign count     = count_q;
    assign empty     = empty_q;
    assign full      = full_q;

`ifdef KEY_QUEUE_DROP_STATS_EN
    logic       ovf_q, ovf_d;
    logic [7:0] drops_q, drops_d;

    // The overflow flag is sticky. The drop count saturates at 255.
    always_comb begin
        ovf_d   = ovf_q | drop;
        drops_d = drops_q;
        if (drop && drops_q != 8'hFF)
            drops_d = drops_q + 8'd1;
    end

    // Drop statistics registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_q   <= 1'b0;
            drops_q <= '0;
        end else begin
            ovf_q   <= ovf_d;
            drops_q <= drops_d;
        end
    end

    assign overflow   = ovf_q;
    assign drop_count = drops_q;
`else
    logic unused_drop;
    assign unused_drop = drop;
    assign overflow    = 1'b0;
    assign drop_count  = 8'd0;
`endif
endmodule

// File: doc/key_queue.md
# key_queue

- Byte queue between the UART receiver and the ASCII-to-PS/2 converter.
- Captures every received byte in a FIFO, so characters arriving while the converter is mid-sequence (make/break/shift) are not lost.
- Releases one byte at a time as a single-cycle latch pulse, only after the downstream PS/2 path has been continuously idle for a programmable settle time.

## Interface

Parameters:
- DEPTH, 16: FIFO entries; power of two, ≥2.
- GAP_CYCLES, 50000: consecutive idle cycles required before issuing (1 ms at 50 MHz); ≥1.

Ports:
- clk  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous, active-high reset. One clock; reset is asynchronous and active-high.
- in_valid  in  1  one-cycle strobe from the UART receiver (its finish pulse).
- in_data  in  8  received byte; valid when in_valid=1.
- sink_idle  in  1  PS/2 transmitter ready; high when downstream is idle.
- out_latch  out  1  one-cycle issue pulse to the converter.
- out_data  out  8  issued byte; held stable until the next issue.
- count  out  $clog2(DEPTH)+1  current occupancy.
- empty  out  1  count==0.
- full  out  1  count==DEPTH.
- overflow  out  1  sticky; set when a byte is dropped.
- drop_count  out  8  saturating count of dropped bytes.

## Operation

- Storage: circular buffer with write and read pointers of $clog2(DEPTH) bits, wrapping modulo DEPTH. count is a register, not derived from pointer difference.
- Push: in_valid=1 and not full, so in_data is written at the write pointer, which then increments.
- Push when full (no pop in the same cycle):
  - byte is discarded;
  - overflow is set;
  - drop_count increments, saturating at 255.
- Gap counter gap_cnt (range 0..GAP_CYCLES):
  - sink_idle=1: increment, saturating at GAP_CYCLES;
  - sink_idle=0: clear to 0;
  - issue edge: clear to 0, which has priority over increment.
- Issue condition, evaluated on registered state: !empty && gap_cnt==GAP_CYCLES. On that edge:
  - out_data ← head entry;
  - out_latch ← 1;
  - read pointer increments.
- out_latch is 0 on every other edge.
- Simultaneous push and issue:
  - both happen, and count is unchanged;
  - when full, the push is accepted because the issue frees a slot in the same edge.
- Bytes the converter does not map still consume a slot and are issued. If the sink never goes busy, the next issue follows after GAP_CYCLES anyway.
- Queue order is strict FIFO. No byte is ever issued twice.

## Timing

Reset values (asynchronous, immediate on assertion):
- out_latch=0, out_data=0, count=0, empty=1, full=0, overflow=0, drop_count=0.
- gap_cnt=0 and both pointers 0.

Latency:
- in_valid in cycle t into an empty queue whose gap_cnt is already saturated gives out_latch=1 in cycle t+2, with out_data equal to that byte.

Spacing:
- Consecutive out_latch pulses are at least GAP_CYCLES+1 cycles apart.
- Any sink_idle=0 cycle restarts the gap count.

Status outputs:
- count, empty and full are registered and update on the edge after the push/pop.

Behaviour around reset:
- No issue occurs within GAP_CYCLES cycles after reset deassertion.
- Reset asserted mid-operation discards queue contents and drops out_latch in the same cycle.

## Configuration

- KEY_QUEUE_DROP_STATS_EN defined: overflow and drop_count behave as above.
- Not defined:
  - both ports are tied to 0;
  - the counter logic is removed;
  - dropping on full is unchanged.

## Test plan

All scenarios use DEPTH=4, GAP_CYCLES=8, with KEY_QUEUE_DROP_STATS_EN defined.

- Single byte: sink_idle=1 for 20 cycles, then in_valid with 0x41 at cycle t → out_latch=1 only at t+2 with out_data=0x41; count returns to 0.
- Burst spacing: push 0x61, 0x62, 0x63 on consecutive cycles with sink_idle=1 → three pulses in order, each 9 cycles apart; empty=1 after the last.
- Busy hold-off: after the first issue, drive sink_idle=0 for 30 cycles, then 1 → the second issue occurs exactly 9 cycles after sink_idle returns high.
- Overflow: sink_idle=0 and six pushes 0x01..0x06 → full=1, count=4, overflow=1, drop_count=2. Releasing sink_idle issues 0x01..0x04 only.
- Full with simultaneous push and issue: at full, an issue edge coinciding with in_valid of 0x55 → count stays 4, no drop, and 0x55 is issued last.
- Reset mid-queue: three bytes queued, pulse reset → count=0, out_latch=0 immediately. No issue within 8 cycles after release, even with sink_idle=1.
